multiface_ctrl: RTL

Parametrised Multiface freezer controller, the successor to the inline MF2 logic in the CPC top level. It turns the freeze key into a Z80 NMI and pages in the Multiface ROM and RAM once the NMI vector is fetched. It handles the hide and enable ports and shadows write-only hardware registers into Multiface RAM. It sits between the motherboard CPU bus and the SDRAM/ROM mux, with RAM size, vectors, port base and ROM page as parameters.

---
 rtl/mf_pkg.sv | 72 +++++++
 rtl/mf_ram.sv | 44 ++++
 rtl/multiface_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mf_pkg.sv
// ---------------------------------------------------------------------------
// mf_pkg
// Shared definitions for the Multiface freezer controller:
//   - FSM state enumeration plus legacy-compatible state constants
//   - Multiface RAM offsets (low 13 bits) for shadowed write-only registers
//   - CPC I/O page numbers that are decoded for shadow capture
//   - shadow_decode(): maps an I/O write to {hit, 13-bit RAM offset}
// Optional feature macro used by the design: MF_SHADOW_EN.
// ---------------------------------------------------------------------------
package mf_pkg;

    typedef enum logic [1:0] {
        MF_IDLE    = 2'd0,
        MF_PENDING = 2'd1,
        MF_ACTIVE  = 2'd2
    } mf_state_e;

    // The controller keeps its state in a plain logic vector for
    // compatibility with older tooling; these mirror the enum above.
    localparam logic [1:0] ST_IDLE    = MF_IDLE;
    localparam logic [1:0] ST_PENDING = MF_PENDING;
    localparam logic [1:0] ST_ACTIVE  = MF_ACTIVE;

    // Shadow locations inside the top 8 KB of Multiface RAM
    localparam logic [12:0] OFF_PEN_SEL   = 13'h1FCF; // last selected pen
    localparam logic [12:0] OFF_BORDER    = 13'h1FDF; // border colour
    localparam logic [12:0] OFF_PEN_BASE  = 13'h1F90; // pens 0..15
    localparam logic [12:0] OFF_MODE      = 13'h1FEF; // mode / ROM config
    localparam logic [12:0] OFF_RAMCFG    = 13'h1FFF; // RAM banking
    localparam logic [12:0] OFF_CRTC_SEL  = 13'h1CFF; // selected CRTC register
    localparam logic [12:0] OFF_CRTC_BASE = 13'h1DB0; // CRTC registers 0..31
    localparam logic [12:0] OFF_PPI_CTRL  = 13'h17FF; // PPI control
    localparam logic [12:0] OFF_ROM_SEL   = 13'h1AAC; // upper ROM select

    // I/O pages (cpu_addr[15:8])
    localparam logic [7:0] PAGE_GA        = 8'h7F;
    localparam logic [7:0] PAGE_CRTC_SEL  = 8'hBC;
    localparam logic [7:0] PAGE_CRTC_DAT  = 8'hBD;
    localparam logic [7:0] PAGE_PPI_CTRL  = 8'hF7;
    localparam logic [7:0] PAGE_ROM_SEL   = 8'hDF;

    // Returns {hit, offset}. pen/crtc are the currently latched selections;
    // the caller is responsible for updating those latches.
    function automatic logic [13:0] shadow_decode(
        input logic [7:0] page,
        input logic [7:0] data,
        input logic [4:0] pen,
        input logic [4:0] crtc
    );
        logic [13:0] r;
        r = '0;
        case (page)
            PAGE_GA: begin
                case (data[7:6])
                    2'b00:   r = {1'b1, OFF_PEN_SEL};
                    2'b01:   r = pen[4] ? {1'b1, OFF_BORDER}
                                        : {1'b1, OFF_PEN_BASE + {9'd0, pen[3:0]}};
                    2'b10:   r = {1'b1, OFF_MODE};
                    default: r = {1'b1, OFF_RAMCFG};
                endcase
            end
            // base + index: 1DB0 has bit 4 set, so OR-ing would alias registers
            PAGE_CRTC_SEL: r = {1'b1, OFF_CRTC_SEL};
            PAGE_CRTC_DAT: r = {1'b1, OFF_CRTC_BASE + {8'd0, crtc}};
            PAGE_PPI_CTRL: r = {1'b1, OFF_PPI_CTRL};
            PAGE_ROM_SEL:  r = {1'b1, OFF_ROM_SEL};
            default:       r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mf_ram.sv
// ---------------------------------------------------------------------------
// mf_ram
// Single-port 2^AW x 8 Multiface RAM. Write-first: a write forwards its data
// to dout on the same clock; otherwise dout shows mem[addr] one clock later.
// Contents are never cleared; only the output register is reset.
// Ports:
//   clk_sys  in   system clock
//   reset_n  in   asynchronous active-low reset (output register only)
//   we       in   write enable
//   addr     in   AW-bit address
//   din      in   write data
//   dout     out  registered read data
// ---------------------------------------------------------------------------
module mf_ram #(
    parameter int AW = 13
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);

    logic [7:0] mem [0:(2**AW)-1];
    logic [7:0] dout_reg;

    always_ff @(posedge clk_sys) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dout_reg <= 8'h00;
        end else begin
            dout_reg <= we ? din : mem[addr];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/multiface_ctrl.sv
// ---------------------------------------------------------------------------
// multiface_ctrl
// Multiface freezer controller: turns the freeze key into a Z80 NMI, pages in
// the Multiface ROM/RAM once the NMI vector is fetched, handles the
// enable/disable ports and the hide vector, and shadows write-only hardware
// registers into Multiface RAM.
// Optional feature macro: MF_SHADOW_EN (register shadow capture). Without it
// only CPU writes reach the RAM.
// Ports:
//   clk_sys     in   system clock
//   reset_n     in   asynchronous active-low reset
//   key_nmi     in   freeze key level
//   mf_allow    in   0 blocks new freeze requests
//   cpu_addr    in   CPU address bus [15:0]
//   m1          in   opcode fetch strobe
//   io_wr       in   I/O write strobe
//   io_dout     in   I/O write data [7:0]
//   ram_wr      in   memory write strobe
//   ram_din     in   memory write data [7:0]
//   nmi         out  NMI request
//   mf_en       out  Multiface paged in
//   mf_hidden   out  Multiface hidden
//   mf_rom_sel  out  ROM window (0000-1FFF) active
//   mf_ram_sel  out  RAM window (2000-3FFF) active
//   rom_addr    out  {ROM_PAGE, cpu_addr[13:0]}
//   ram_dout    out  Multiface RAM read data
// ---------------------------------------------------------------------------
module multiface_ctrl
    import mf_pkg::*;
#(
    parameter int          RAM_AW    = 13,
    parameter logic [8:0]  ROM_PAGE  = 9'h1FF,
    parameter logic [15:0] NMI_VEC   = 16'h0066,
    parameter logic [15:0] HIDE_VEC  = 16'h0065,
    parameter logic [15:0] PORT_BASE = 16'hFEE8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        key_nmi,
    input  logic        mf_allow,
    input  logic [15:0] cpu_addr,
    input  logic        m1,
    input  logic        io_wr,
    input  logic [7:0]  io_dout,
    input  logic        ram_wr,
    input  logic [7:0]  ram_din,
    output logic        nmi,
    output logic        mf_en,
    output logic        mf_hidden,
    output logic        mf_rom_sel,
    output logic        mf_ram_sel,
    output logic [22:0] rom_addr,
    output logic [7:0]  ram_dout
);

    // Shadow offsets are 13 bits; larger RAMs place them in the top 8 KB.
    localparam logic [RAM_AW-1:0] SHADOW_HI = {RAM_AW{1'b1}} << 13;

    logic key_nmi_reg, m1_reg, io_wr_reg;
    logic key_rise, m1_rise, io_rise;

    logic [1:0] state_reg, state_next;
    logic       nmi_reg, nmi_next;
    logic       mf_en_reg, mf_en_next;
    logic       mf_hidden_reg, mf_hidden_next;

    logic port_hit, port_en_wr, port_dis_wr;

    logic              shadow_hit;
    logic [12:0]       shadow_off;
    logic              shadow_we;
    logic [RAM_AW-1:0] shadow_addr;

    logic              cpu_we;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_wdata;

    // ---------------------------------------------------------------- edges
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            key_nmi_reg <= 1'b0;
            m1_reg      <= 1'b0;
            io_wr_reg   <= 1'b0;
        end else begin
            key_nmi_reg <= key_nmi;
            m1_reg      <= m1;
            io_wr_reg   <= io_wr;
        end
    end

    assign key_rise = key_nmi & ~key_nmi_reg;
    assign m1_rise  = m1 & ~m1_reg;
    assign io_rise  = io_wr & ~io_wr_reg;

    // ---------------------------------------------------------- port decode
    assign port_hit    = io_rise && (cpu_addr[15:2] == PORT_BASE[15:2]);
    assign port_en_wr  = port_hit & ~cpu_addr[1];
    assign port_dis_wr = port_hit &  cpu_addr[1];

    // ------------------------------------------------------------------ FSM
    always_comb begin
        state_next     = state_reg;
        nmi_next       = nmi_reg;
        mf_en_next     = mf_en_reg;
        mf_hidden_next = mf_hidden_reg;
        case (state_reg)
            ST_IDLE: begin
                if (key_rise && mf_allow) begin
                    state_next = ST_PENDING;
                    nmi_next   = 1'b1;
                end else if (port_en_wr && !mf_hidden_reg) begin
                    // software re-enable of a paged-out, unhidden Multiface
                    mf_en_next = 1'b1;
                    state_next = ST_ACTIVE;
                end
            end
            ST_PENDING: begin
                // further key presses and mf_allow changes are ignored here
                if (m1_rise && (cpu_addr == NMI_VEC)) begin
                    state_next     = ST_ACTIVE;
                    nmi_next       = 1'b0;
                    mf_en_next     = 1'b1;
                    mf_hidden_next = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (m1_rise && (cpu_addr == HIDE_VEC)) begin
                    mf_hidden_next = 1'b1;
                end
                if (port_dis_wr) begin
                    mf_en_next = 1'b0;
                end else if (port_en_wr) begin
                    mf_en_next = ~mf_hidden_reg;
                end
                if (!mf_en_next) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                nmi_next   = 1'b0;
                mf_en_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            nmi_reg       <= 1'b0;
            mf_en_reg     <= 1'b0;
            mf_hidden_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            nmi_reg       <= nmi_next;
            mf_en_reg     <= mf_en_next;
            mf_hidden_reg <= mf_hidden_next;
        end
    end

    // -------------------------------------------------------- shadow capture
`ifdef MF_SHADOW_EN
    logic [4:0] pen_reg;
    logic [4:0] crtc_reg;

    // Decode uses the pen/CRTC selection latched by earlier writes.
    assign {shadow_hit, shadow_off} = shadow_decode(cpu_addr[15:8], io_dout,
                                                    pen_reg, crtc_reg);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pen_reg  <= 5'd0;
            crtc_reg <= 5'd0;
        end else if (io_rise && !port_hit) begin
            if (cpu_addr[15:8] == PAGE_GA && io_dout[7:6] == 2'b00) begin
                pen_reg <= io_dout[4:0];
            end
            if (cpu_addr[15:8] == PAGE_CRTC_SEL) begin
                crtc_reg <= io_dout[4:0];
            end
        end
    end
`else
    assign shadow_hit = 1'b0;
    assign shadow_off = 13'd0;
`endif

    assign shadow_we   = io_rise & shadow_hit & ~port_hit;
    assign shadow_addr = SHADOW_HI | RAM_AW'(shadow_off);

    // ---------------------------------------------------------- RAM access
    assign mf_rom_sel = mf_en_reg && (cpu_addr[15:13] == 3'b000);
    assign mf_ram_sel = mf_en_reg && (cpu_addr[15:13] == 3'b001);
    assign rom_addr   = {ROM_PAGE, cpu_addr[13:0]};

    // Port write > shadow capture > CPU write; a colliding CPU write is dropped.
    assign cpu_we    = ram_wr & mf_ram_sel & ~port_hit & ~shadow_we;
    assign ram_we    = shadow_we | cpu_we;
    assign ram_addr  = shadow_we ? shadow_addr : cpu_addr[RAM_AW-1:0];
    assign ram_wdata = shadow_we ? io_dout : ram_din;

    mf_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .we      (ram_we),
        .addr    (ram_addr),
        .din     (ram_wdata),
        .dout    (ram_dout)
    );

    assign nmi       = nmi_reg;
    assign mf_en     = mf_en_reg;
    assign mf_hidden = mf_hidden_reg;

endmodule
